// File: rtl/data_mem_responder.sv
// data_mem_responder: single-port word memory behind a 2-entry in-order
// request queue with a programmable number of wait states per access.
// Requests are accepted while the queue is not full and complete in order,
// each with a one-cycle gnt_o carrying rdata_o/err_o.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        bus_cyc_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  be_i,
    output logic        gnt_o,
    output logic        stall_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);

    localparam int AW = $clog2(DEPTH_WORDS);
    // Queue entry layout: {we, be[3:0], wdata[31:0], word_addr[29:0]}.
    // The byte offset addr_i[1:0] never affects an access, so it is not stored.
    localparam int EW = 67;
    localparam logic [2:0] WS_LOAD = 3'(WAIT_STATES);

    logic [EW-1:0] slot0_q, slot0_d;
    logic [EW-1:0] slot1_q, slot1_d;
    logic [1:0]    count_q, count_d;
    logic [2:0]    wait_q, wait_d;
    logic          gnt_q, gnt_d;
    logic          err_q, err_d;
    logic [31:0]   rdata_q, rdata_d;

    logic [31:0]   mem [DEPTH_WORDS];

    logic          head_we_s;
    logic [3:0]    head_be_s;
    logic [31:0]   head_wdata_s;
    logic [29:0]   head_word_s;
    logic [AW-1:0] head_idx_s;
    logic          head_oor_s;
    logic          accept_s;
    logic          exec_s;
    logic          mem_we_s;
    logic [1:0]    pop_count_s;
    logic [EW-1:0] new_entry_s;
    logic          unused_addr_lsb_s;

    assign head_we_s    = slot0_q[66];
    assign head_be_s    = slot0_q[65:62];
    assign head_wdata_s = slot0_q[61:30];
    assign head_word_s  = slot0_q[29:0];
    assign head_idx_s   = head_word_s[AW-1:0];
    // Any set bit above the index field means the byte address is >= 4*DEPTH_WORDS.
    assign head_oor_s   = |head_word_s[29:AW];

    assign new_entry_s       = {we_i, be_i, wdata_i, addr_i[31:2]};
    assign unused_addr_lsb_s = ^addr_i[1:0];

    // Stall is a pure decode of registered occupancy, never of inputs.
    assign stall_o  = (count_q == 2'd2);
    assign accept_s = bus_cyc_i && req_i && (count_q != 2'd2);
    assign exec_s   = bus_cyc_i && (count_q != 2'd0) && (wait_q == 3'd0);
    assign mem_we_s = exec_s && head_we_s && !head_oor_s;

    assign gnt_o   = gnt_q;
    assign rdata_o = rdata_q;
    assign err_o   = err_q;

    // Next-state: retire the head on execute, append an accepted request, reload/count wait states.
    always_comb begin
        slot0_d     = slot0_q;
        slot1_d     = slot1_q;
        count_d     = count_q;
        wait_d      = wait_q;
        gnt_d       = 1'b0;
        err_d       = 1'b0;
        rdata_d     = 32'd0;
        pop_count_s = count_q;
        if (!bus_cyc_i) begin
            // Bus cycle dropped: abandon everything queued, nothing executes.
            count_d = 2'd0;
            wait_d  = 3'd0;
        end else begin
            if (exec_s) begin
                gnt_d       = 1'b1;
                err_d       = head_oor_s;
                if (!head_we_s && !head_oor_s) begin
                    rdata_d = mem[head_idx_s];
                end else begin
                    rdata_d = 32'd0;
                end
                slot0_d     = slot1_q;
                pop_count_s = count_q - 2'd1;
            end else begin
                pop_count_s = count_q;
            end
            if (accept_s) begin
                if (pop_count_s == 2'd0) begin
                    slot0_d = new_entry_s;
                end else begin
                    slot1_d = new_entry_s;
                end
            end else begin
                slot1_d = slot1_q;
            end
            count_d = pop_count_s + {1'b0, accept_s};
            // A new head appears either after a retire with work left, or on entry into an empty queue.
            if ((exec_s || (count_q == 2'd0)) && (count_d != 2'd0)) begin
                wait_d = WS_LOAD;
            end else if (wait_q != 3'd0) begin
                wait_d = wait_q - 3'd1;
            end else begin
                wait_d = wait_q;
            end
        end
    end

    // Queue, wait counter and registered response outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            slot0_q <= '0;
            slot1_q <= '0;
            count_q <= 2'd0;
            wait_q  <= 3'd0;
            gnt_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
            count_q <= count_d;
            wait_q  <= wait_d;
            gnt_q   <= gnt_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // Byte-enabled memory write; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            for (int n = 0; n < 4; n++) begin
                if (head_be_s[n]) begin
                    mem[head_idx_s][8*n +: 8] <= head_wdata_s[8*n +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: three instances (WAIT_STATES 0, 1, 3) share one
// stimulus stream; a queue/deadline reference model per instance predicts every
// output each cycle, and directed scenarios add constant-valued checks.
module tb_data_mem_responder;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } req_t;

    typedef struct {
        int          cyc;
        logic [31:0] rdata;
        logic        err;
    } gnt_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        bus_cyc_r = 1'b0;
    logic        req_r = 1'b0;
    logic        we_r = 1'b0;
    logic [31:0] addr_r = 32'd0;
    logic [31:0] wdata_r = 32'd0;
    logic [3:0]  be_r = 4'd0;

    logic        gnt_w   [3];
    logic        stall_w [3];
    logic        err_w   [3];
    logic [31:0] rdata_w [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        data_mem_responder #(
            .DEPTH_WORDS(1024),
            .WAIT_STATES((g == 0) ? 0 : ((g == 1) ? 1 : 3))
        ) u_dut (
            .clk      (clk),
            .rstn     (rstn),
            .bus_cyc_i(bus_cyc_r),
            .req_i    (req_r),
            .we_i     (we_r),
            .addr_i   (addr_r),
            .wdata_i  (wdata_r),
            .be_i     (be_r),
            .gnt_o    (gnt_w[g]),
            .stall_o  (stall_w[g]),
            .rdata_o  (rdata_w[g]),
            .err_o    (err_w[g])
        );
    end

    // Reference model state, one per instance.
    req_t        mq [3][$];
    gnt_t        gq [3][$];
    logic [31:0] mm [3][1024];
    int          head_exec [3];
    logic        exp_gnt [3];
    logic        exp_err [3];
    logic [31:0] exp_rdata [3];
    bit          acc [3];
    int          acc_e [3];

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int last_e = 0;

    function automatic int ws_of(int k);
        return (k == 0) ? 0 : ((k == 1) ? 1 : 3);
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference behaviour at one rising edge: the head executes when its deadline edge
    // arrives; a request joins when fewer than two are waiting; a new head gets a
    // deadline WAIT_STATES+1 edges ahead.
    task automatic model_edge(int e);
        req_t r;
        int   old;
        bit   popped;
        bit   oor;
        for (int k = 0; k < 3; k++) begin
            acc[k]       = 1'b0;
            exp_gnt[k]   = 1'b0;
            exp_err[k]   = 1'b0;
            exp_rdata[k] = 32'd0;
            if (!rstn || !bus_cyc_r) begin
                mq[k].delete();
                continue;
            end
            old    = mq[k].size();
            popped = 1'b0;
            if (old > 0 && e == head_exec[k]) begin
                r      = mq[k].pop_front();
                popped = 1'b1;
                oor    = (r.addr >= 32'd4096);
                exp_gnt[k] = 1'b1;
                exp_err[k] = oor;
                if (r.we) begin
                    if (!oor) begin
                        for (int b = 0; b < 4; b++) begin
                            if (r.be[b]) mm[k][r.addr[11:2]][8*b +: 8] = r.wdata[8*b +: 8];
                        end
                    end
                end else begin
                    exp_rdata[k] = oor ? 32'd0 : mm[k][r.addr[11:2]];
                end
            end
            if (req_r && old < 2) begin
                r.we = we_r; r.addr = addr_r; r.wdata = wdata_r; r.be = be_r;
                mq[k].push_back(r);
                acc[k] = 1'b1;
            end
            if (mq[k].size() > 0 && (popped || old == 0)) head_exec[k] = e + ws_of(k) + 1;
        end
    endtask

    // One clock: model the edge, then compare every instance just after it.
    task automatic tick();
        gnt_t gr;
        model_edge(cyc);
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("gnt%0d@%0d", k, cyc), {31'd0, gnt_w[k]}, {31'd0, exp_gnt[k]});
            chk($sformatf("err%0d@%0d", k, cyc), {31'd0, err_w[k]}, {31'd0, exp_err[k]});
            chk($sformatf("rdata%0d@%0d", k, cyc), rdata_w[k], exp_rdata[k]);
            chk($sformatf("stall%0d@%0d", k, cyc), {31'd0, stall_w[k]}, {31'd0, mq[k].size() == 2});
            if (gnt_w[k] === 1'b1) begin
                gr.cyc = cyc; gr.rdata = rdata_w[k]; gr.err = err_w[k];
                gq[k].push_back(gr);
            end
        end
        last_e = cyc;
        cyc++;
    endtask

    // Hold a request until every instance has taken it (faster ones may take it again).
    task automatic do_req(bit we, logic [31:0] a, logic [31:0] d, logic [3:0] be);
        bit got [3];
        int n;
        got = '{1'b0, 1'b0, 1'b0};
        n = 0;
        we_r = we; addr_r = a; wdata_r = d; be_r = be; req_r = 1'b1;
        while (!(got[0] && got[1] && got[2]) && n < 30) begin
            tick();
            for (int k = 0; k < 3; k++) begin
                if (acc[k] && !got[k]) begin
                    got[k]   = 1'b1;
                    acc_e[k] = last_e;
                end
            end
            n++;
        end
        req_r = 1'b0;
        chk("accept_timeout", {31'd0, got[0] & got[1] & got[2]}, 32'd1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((mq[0].size() + mq[1].size() + mq[2].size()) != 0 && n < 60) begin
            tick();
            n++;
        end
        chk("idle_timeout", 32'(mq[0].size() + mq[1].size() + mq[2].size()), 32'd0);
        tick();
    endtask

    task automatic req_idle(bit we, logic [31:0] a, logic [31:0] d, logic [3:0] be);
        do_req(we, a, d, be);
        wait_idle();
    endtask

    task automatic chk_last(string tag, int k, logic [31:0] rd, logic er);
        chk({tag, "_seen"}, {31'd0, gq[k].size() > 0}, 32'd1);
        if (gq[k].size() > 0) begin
            chk({tag, "_rdata"}, gq[k][$].rdata, rd);
            chk({tag, "_err"}, {31'd0, gq[k][$].err}, {31'd0, er});
        end
    endtask

    initial begin
        int sz [3];
        int a0, a2, ce, late, rel_e;

        // Reset state
        tick();
        tick();
        rstn = 1'b1;
        bus_cyc_r = 1'b1;

        // Preload words 0..15 with 0xC0DE00nn
        for (int i = 0; i < 16; i++) do_req(1'b1, 32'(i * 4), 32'hC0DE_0000 | 32'(i), 4'hF);
        wait_idle();

        // Full-word write then read at 0x10, latency WAIT_STATES+1
        for (int k = 0; k < 3; k++) gq[k].delete();
        req_idle(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        for (int k = 0; k < 3; k++) begin
            chk_last("wr10", k, 32'd0, 1'b0);
            if (gq[k].size() > 0) chk("wr10_lat", 32'(gq[k][$].cyc - acc_e[k]), 32'(ws_of(k) + 1));
        end
        req_idle(1'b0, 32'h10, 32'd0, 4'h0);
        for (int k = 0; k < 3; k++) begin
            chk_last("rd10", k, 32'hDEADBEEF, 1'b0);
            if (gq[k].size() > 0) chk("rd10_lat", 32'(gq[k][$].cyc - acc_e[k]), 32'(ws_of(k) + 1));
        end

        // Single-lane write: byte 0xAA placed on lane 1
        req_idle(1'b1, 32'h20, 32'h11223344, 4'hF);
        req_idle(1'b1, 32'h20, 32'h0000AA00, 4'b0010);
        req_idle(1'b0, 32'h22, 32'd0, 4'h1);
        for (int k = 0; k < 3; k++) chk_last("rd20", k, 32'h1122AA44, 1'b0);

        // Three back-to-back reads on the WAIT_STATES=3 instance
        gq[2].delete();
        do_req(1'b0, 32'h0, 32'd0, 4'hF);
        a0 = acc_e[2];
        do_req(1'b0, 32'h4, 32'd0, 4'hF);
        chk("b2b_stall", {31'd0, stall_w[2]}, 32'd1);
        do_req(1'b0, 32'h8, 32'd0, 4'hF);
        a2 = acc_e[2];
        wait_idle();
        chk("b2b_count", 32'(gq[2].size()), 32'd3);
        if (gq[2].size() == 3) begin
            chk("b2b_lat", 32'(gq[2][0].cyc - a0), 32'd4);
            chk("b2b_gap1", 32'(gq[2][1].cyc - gq[2][0].cyc), 32'd4);
            chk("b2b_gap2", 32'(gq[2][2].cyc - gq[2][1].cyc), 32'd4);
            chk("b2b_third_acc", 32'(a2 - gq[2][0].cyc), 32'd1);
            chk("b2b_rd0", gq[2][0].rdata, 32'hC0DE0000);
            chk("b2b_rd1", gq[2][1].rdata, 32'hC0DE0001);
            chk("b2b_rd2", gq[2][2].rdata, 32'hC0DE0002);
        end

        // Out-of-range accesses
        req_idle(1'b1, 32'h0, 32'h01234567, 4'hF);
        req_idle(1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF);
        for (int k = 0; k < 3; k++) chk_last("oor_wr", k, 32'd0, 1'b1);
        req_idle(1'b0, 32'h1000, 32'd0, 4'hF);
        for (int k = 0; k < 3; k++) chk_last("oor_rd", k, 32'd0, 1'b1);
        req_idle(1'b0, 32'h0, 32'd0, 4'hF);
        for (int k = 0; k < 3; k++) chk_last("word0", k, 32'h01234567, 1'b0);

        // Cancel: write queued behind a pending read, bus cycle dropped once
        do_req(1'b0, 32'h8, 32'd0, 4'hF);
        do_req(1'b1, 32'h8, 32'h00000055, 4'hF);
        bus_cyc_r = 1'b0;
        tick();
        ce = last_e;
        bus_cyc_r = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        for (int k = 0; k < 3; k++) begin
            late = 0;
            foreach (gq[k][j]) if (gq[k][j].cyc >= ce) late++;
            chk("cancel_no_gnt", 32'(late), 32'd0);
        end
        req_idle(1'b0, 32'h8, 32'd0, 4'hF);
        for (int k = 0; k < 3; k++) chk_last("cancel_rd8", k, 32'hC0DE0002, 1'b0);

        // Reset pulsed in the cycle after an accept
        do_req(1'b1, 32'h14, 32'h77777777, 4'hF);
        rstn = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("rst_gnt", {31'd0, gnt_w[k]}, 32'd0);
            chk("rst_stall", {31'd0, stall_w[k]}, 32'd0);
            chk("rst_rdata", rdata_w[k], 32'd0);
            chk("rst_err", {31'd0, err_w[k]}, 32'd0);
        end
        tick();
        rel_e = last_e;
        rstn = 1'b1;
        for (int k = 0; k < 3; k++) sz[k] = gq[k].size();
        do_req(1'b0, 32'h14, 32'd0, 4'hF);
        wait_idle();
        for (int k = 0; k < 3; k++) begin
            chk("rst_gnt_count", 32'(gq[k].size() - sz[k]), 32'd1);
            chk_last("rst_rd14", k, 32'hC0DE0005, 1'b0);
            if (gq[k].size() > 0) chk("rst_first_acc", 32'(gq[k][$].cyc - rel_e), 32'(ws_of(k) + 2));
        end

        // Random traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            bus_cyc_r = ($urandom_range(0, 19) != 0);
            req_r     = ($urandom_range(0, 9) < 6);
            we_r      = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 9) < 8) addr_r = 32'(($urandom_range(0, 15) << 2) | $urandom_range(0, 3));
            else addr_r = $urandom() | 32'h0000_1000;
            wdata_r = $urandom();
            be_r    = 4'($urandom_range(0, 15));
            tick();
        end
        bus_cyc_r = 1'b1;
        req_r = 1'b0;
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
